// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward Ethernet RX FIFO: frames become visible 2 cycles after the commit edge, and only complete good frames are released.
// There is no input stall, so overflow or a MAC error drops the whole frame; the output holds its data while i_rx_ready is low.
module eth_rx_frame_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 11,
  parameter bit DROP_ERRORED = 1'b1,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   i_clk,
  input  logic                   rst,
  input  logic                   i_rx_valid,
  input  logic [DATA_WIDTH-1:0]  i_rx_data,
  input  logic                   i_rx_last,
  input  logic                   i_rx_user,
  output logic                   o_rx_valid,
  output logic [DATA_WIDTH-1:0]  o_rx_data,
  output logic                   o_rx_last,
  input  logic                   i_rx_ready,
  output logic [ADDR_WIDTH:0]    o_level,
  output logic [COUNT_WIDTH-1:0] o_frames_ok,
  output logic [COUNT_WIDTH-1:0] o_drop_overflow,
  output logic [COUNT_WIDTH-1:0] o_drop_error
);

  localparam int                     DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]    PTR_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]    PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RECV, DROP} wr_state_t;

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [DATA_WIDTH:0] ram_q;

  wr_state_t           state, state_n;
  logic [ADDR_WIDTH:0] wr_ptr, wr_ptr_n;
  logic [ADDR_WIDTH:0] wr_commit, wr_commit_n;
  logic [ADDR_WIDTH:0] rd_ptr, rd_ptr_n;
  logic [ADDR_WIDTH:0] rd_fetch;
  logic                full, wr_en, inc_ok, inc_err, inc_ovf;
  logic                r_vld, out_free, rd_en;

  // rd_ptr only moves on an output handshake, so beats in the read pipeline still count as occupied
  assign full     = (wr_ptr - rd_ptr) == PTR_FULL;
  assign out_free = ~o_rx_valid | i_rx_ready;
  assign rd_en    = (wr_commit != rd_fetch) & (~r_vld | out_free);
  assign rd_ptr_n = (o_rx_valid & i_rx_ready) ? rd_ptr + PTR_ONE : rd_ptr;

  always_comb begin
    state_n     = state;
    wr_ptr_n    = wr_ptr;
    wr_commit_n = wr_commit;
    wr_en       = 1'b0;
    inc_ok      = 1'b0;
    inc_err     = 1'b0;
    inc_ovf     = 1'b0;
    if (i_rx_valid) begin
      case (state)
        IDLE, RECV: begin
          if (full) begin
            wr_ptr_n = wr_commit;
            inc_ovf  = 1'b1;
            state_n  = i_rx_last ? IDLE : DROP;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_n = wr_ptr + PTR_ONE;
            state_n  = RECV;
            if (i_rx_last) begin
              state_n = IDLE;
              if (i_rx_user && DROP_ERRORED) begin
                wr_ptr_n = wr_commit;
                inc_err  = 1'b1;
              end else begin
                wr_commit_n = wr_ptr + PTR_ONE;
                inc_ok      = 1'b1;
              end
            end
          end
        end
        DROP: begin
          if (i_rx_last) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {i_rx_last, i_rx_data};
    if (rd_en) ram_q <= mem[rd_fetch[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      wr_commit       <= '0;
      rd_ptr          <= '0;
      rd_fetch        <= '0;
      r_vld           <= 1'b0;
      o_rx_valid      <= 1'b0;
      o_rx_data       <= '0;
      o_rx_last       <= 1'b0;
      o_level         <= '0;
      o_frames_ok     <= '0;
      o_drop_overflow <= '0;
      o_drop_error    <= '0;
    end else begin
      state     <= state_n;
      wr_ptr    <= wr_ptr_n;
      wr_commit <= wr_commit_n;
      rd_ptr    <= rd_ptr_n;
      o_level   <= wr_ptr_n - rd_ptr_n;
      if (rd_en) rd_fetch <= rd_fetch + PTR_ONE;
      // RAM output register acts as the prefetch stage and holds while the output is stalled
      r_vld <= rd_en | (r_vld & ~out_free);
      if (out_free) begin
        o_rx_valid <= r_vld;
        if (r_vld) {o_rx_last, o_rx_data} <= ram_q;
      end
      if (inc_ok)  o_frames_ok     <= o_frames_ok + CNT_ONE;
      if (inc_ovf) o_drop_overflow <= o_drop_overflow + CNT_ONE;
      if (inc_err) o_drop_error    <= o_drop_error + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Bench for eth_rx_frame_fifo with a 64-deep buffer: a frame-level reference model feeds a scoreboard queue.
module tb_eth_rx_frame_fifo;

  localparam int DEPTH = 64;

  logic        i_clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_rx_valid = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic        i_rx_last = 1'b0;
  logic        i_rx_user = 1'b0;
  logic        o_rx_valid;
  logic [7:0]  o_rx_data;
  logic        o_rx_last;
  logic        i_rx_ready = 1'b0;
  logic [6:0]  o_level;
  logic [15:0] o_frames_ok, o_drop_overflow, o_drop_error;

  eth_rx_frame_fifo #(
    .DATA_WIDTH(8), .ADDR_WIDTH(6), .DROP_ERRORED(1'b1), .COUNT_WIDTH(16)
  ) dut (
    .i_clk(i_clk), .rst(rst),
    .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .i_rx_last(i_rx_last), .i_rx_user(i_rx_user),
    .o_rx_valid(o_rx_valid), .o_rx_data(o_rx_data), .o_rx_last(o_rx_last), .i_rx_ready(i_rx_ready),
    .o_level(o_level), .o_frames_ok(o_frames_ok),
    .o_drop_overflow(o_drop_overflow), .o_drop_error(o_drop_error)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  logic [8:0] cur_frame[$];
  int   m_occ, m_unc, exp_ok, exp_ovf, exp_err, pops, committed_beats;
  bit   m_drop, rand_rdy, stall_prev;
  logic [8:0] held;

  // One clock: check the output side, advance the reference model for the driven beat, then move to #1 after the edge.
  task automatic step();
    logic [8:0] e;
    bit take;
    if (rand_rdy) i_rx_ready = ($urandom_range(0, 3) != 0);
    take = 1'b0;
    if (rst) begin
      exp_q.delete(); cur_frame.delete();
      m_occ = 0; m_unc = 0; m_drop = 0; exp_ok = 0; exp_ovf = 0; exp_err = 0;
      pops = 0; committed_beats = 0; stall_prev = 0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (o_rx_valid !== 1'b1 || {o_rx_last, o_rx_data} !== held) begin
          errors++;
          $display("FAIL hold: valid=%b beat=%h, expected valid=1 beat=%h", o_rx_valid, {o_rx_last, o_rx_data}, held);
        end
      end
      stall_prev = (o_rx_valid === 1'b1) && !i_rx_ready;
      held = {o_rx_last, o_rx_data};
      if (o_rx_valid === 1'b1 && i_rx_ready) begin
        take = 1'b1;
        pops++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h, expected no output", {o_rx_last, o_rx_data});
        end else begin
          e = exp_q.pop_front();
          if ({o_rx_last, o_rx_data} !== e) begin
            errors++;
            $display("FAIL out_beat: got %h, expected %h", {o_rx_last, o_rx_data}, e);
          end
        end
      end
      if (i_rx_valid) begin
        if (m_drop) begin
          if (i_rx_last) m_drop = 0;
        end else if (m_occ == DEPTH) begin
          m_occ -= m_unc; m_unc = 0; cur_frame.delete(); exp_ovf++;
          if (!i_rx_last) m_drop = 1;
        end else begin
          m_occ++; m_unc++;
          cur_frame.push_back({i_rx_last, i_rx_data});
          if (i_rx_last) begin
            if (i_rx_user) begin
              m_occ -= m_unc; exp_err++;
            end else begin
              foreach (cur_frame[k]) exp_q.push_back(cur_frame[k]);
              exp_ok++; committed_beats += m_unc;
            end
            m_unc = 0; cur_frame.delete();
          end
        end
      end
      if (take) m_occ--;
    end
    @(posedge i_clk); #1;
  endtask

  task automatic send_frame(input int len, input bit user, input bit counting);
    for (int i = 0; i < len; i++) begin
      i_rx_valid = 1'b1;
      i_rx_data  = counting ? 8'(i + 1) : 8'($urandom);
      i_rx_last  = (i == len - 1);
      i_rx_user  = (i == len - 1) ? user : 1'($urandom);
      step();
    end
    i_rx_valid = 1'b0; i_rx_last = 1'b0; i_rx_user = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_rx_valid = 1'b0; i_rx_last = 1'b0; i_rx_user = 1'b0; i_rx_data = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    i_rx_ready = 1'b1;
    do_reset();
    checks++;
    if ({o_rx_valid, o_rx_last, o_rx_data, o_level} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b last=%b data=%h level=%0d, expected all 0", o_rx_valid, o_rx_last, o_rx_data, o_level);
    end
    checks++;
    if ({o_frames_ok, o_drop_overflow, o_drop_error} !== '0) begin
      errors++;
      $display("FAIL reset_counters: ok=%0d ovf=%0d err=%0d, expected 0", o_frames_ok, o_drop_overflow, o_drop_error);
    end
  endtask

  task automatic test_single();
    do_reset();
    i_rx_ready = 1'b1;
    send_frame(64, 1'b0, 1'b1);
    checks++;
    if (o_rx_valid !== 1'b0) begin errors++; $display("FAIL latency_e0: valid=%b, expected 0", o_rx_valid); end
    step();
    checks++;
    if (o_rx_valid !== 1'b0) begin errors++; $display("FAIL latency_e1: valid=%b, expected 0", o_rx_valid); end
    step();
    checks++;
    if (o_rx_valid !== 1'b1) begin errors++; $display("FAIL latency_e2: valid=%b, expected 1", o_rx_valid); end
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
    checks++;
    if (exp_q.size() != 0 || pops != 64) begin
      errors++; $display("FAIL single_drain: beats out=%0d left=%0d, expected 64 out 0 left", pops, exp_q.size());
    end
    checks++;
    if (o_frames_ok !== 16'd1 || o_level !== 7'd0) begin
      errors++; $display("FAIL single_counts: ok=%0d level=%0d, expected ok=1 level=0", o_frames_ok, o_level);
    end
  endtask

  task automatic test_error();
    do_reset();
    i_rx_ready = 1'b1;
    send_frame(60, 1'b1, 1'b0);
    send_frame(60, 1'b0, 1'b0);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
    checks++;
    if (exp_q.size() != 0 || pops != 60) begin
      errors++; $display("FAIL error_drain: beats out=%0d left=%0d, expected 60 out 0 left", pops, exp_q.size());
    end
    checks++;
    if ({o_frames_ok, o_drop_overflow, o_drop_error} !== {16'd1, 16'd0, 16'd1} || o_level !== 7'd0) begin
      errors++;
      $display("FAIL error_counts: ok=%0d ovf=%0d err=%0d level=%0d, expected 1 0 1 level 0", o_frames_ok, o_drop_overflow, o_drop_error, o_level);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    i_rx_ready = 1'b0;
    send_frame(40, 1'b0, 1'b0);
    send_frame(40, 1'b0, 1'b0);
    send_frame(20, 1'b0, 1'b0);
    checks++;
    if (o_level !== 7'd60) begin errors++; $display("FAIL ovf_level: level=%0d, expected 60", o_level); end
    checks++;
    if ({o_frames_ok, o_drop_overflow, o_drop_error} !== {16'd2, 16'd1, 16'd0}) begin
      errors++;
      $display("FAIL ovf_counts: ok=%0d ovf=%0d err=%0d, expected 2 1 0", o_frames_ok, o_drop_overflow, o_drop_error);
    end
    i_rx_ready = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
    checks++;
    if (exp_q.size() != 0 || pops != 60 || o_level !== 7'd0) begin
      errors++; $display("FAIL ovf_drain: beats out=%0d left=%0d level=%0d, expected 60 0 0", pops, exp_q.size(), o_level);
    end
  endtask

  task automatic test_oversize();
    do_reset();
    i_rx_ready = 1'b1;
    send_frame(100, 1'b0, 1'b0);
    checks++;
    if (o_level !== 7'd0 || o_drop_overflow !== 16'd1 || o_rx_valid !== 1'b0) begin
      errors++; $display("FAIL oversize_drop: level=%0d ovf=%0d valid=%b, expected 0 1 0", o_level, o_drop_overflow, o_rx_valid);
    end
    send_frame(10, 1'b0, 1'b1);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
    checks++;
    if (exp_q.size() != 0 || pops != 10 || o_frames_ok !== 16'd1) begin
      errors++; $display("FAIL oversize_next: beats out=%0d left=%0d ok=%0d, expected 10 0 1", pops, exp_q.size(), o_frames_ok);
    end
  endtask

  task automatic test_back_to_back();
    int len;
    do_reset();
    rand_rdy = 1'b1;
    for (int f = 0; f < 80; f++) begin
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(65, 1518) : $urandom_range(1, 64);
      send_frame(len, ($urandom_range(0, 7) == 0), 1'b0);
    end
    rand_rdy = 1'b0;
    i_rx_ready = 1'b1;
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) step();
    checks++;
    if (exp_q.size() != 0 || o_level !== 7'd0) begin
      errors++; $display("FAIL random_drain: left=%0d level=%0d, expected 0 0", exp_q.size(), o_level);
    end
    checks++;
    if ({o_frames_ok, o_drop_overflow, o_drop_error} !== {16'(exp_ok), 16'(exp_ovf), 16'(exp_err)}) begin
      errors++;
      $display("FAIL random_counts: ok=%0d ovf=%0d err=%0d, expected %0d %0d %0d",
               o_frames_ok, o_drop_overflow, o_drop_error, exp_ok, exp_ovf, exp_err);
    end
    checks++;
    if (committed_beats < 3 * 2 * DEPTH) begin
      errors++; $display("FAIL random_wrap: committed beats=%0d, expected >= %0d", committed_beats, 3 * 2 * DEPTH);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_rx_ready = 1'b1;
    send_frame(30, 1'b0, 1'b1);
    for (int i = 0; i < 100 && pops < 4; i++) step();
    checks++;
    if (pops != 4 || o_rx_valid !== 1'b1 || o_rx_data !== 8'd5) begin
      errors++; $display("FAIL mid_beat5: pops=%0d valid=%b data=%0d, expected 4 1 5", pops, o_rx_valid, o_rx_data);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({o_rx_valid, o_rx_last, o_rx_data, o_level, o_frames_ok, o_drop_overflow, o_drop_error} !== '0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b last=%b data=%h level=%0d ok=%0d ovf=%0d err=%0d, expected all 0",
               o_rx_valid, o_rx_last, o_rx_data, o_level, o_frames_ok, o_drop_overflow, o_drop_error);
    end
    rst = 1'b0;
    send_frame(12, 1'b0, 1'b0);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
    checks++;
    if (exp_q.size() != 0 || pops != 12 || o_frames_ok !== 16'd1) begin
      errors++; $display("FAIL mid_after: beats out=%0d left=%0d ok=%0d, expected 12 0 1", pops, exp_q.size(), o_frames_ok);
    end
  endtask

  initial begin
    rand_rdy = 1'b0;
    #1;
    test_reset();
    test_single();
    test_error();
    test_overflow();
    test_oversize();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
